// File: rtl/iterative_alu.sv
// Multi-cycle 32-bit ALU with valid/ready on both sides; shifts iterate one bit per cycle.
// Define ITERATIVE_ALU_BARREL_EN to complete every shift in one cycle through a barrel shifter.
module iterative_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zf,
    output logic        sf,
    output logic        cf,
    output logic        vf,
    output logic [1:0]  dbg_state
);

    // Selection codes shared with the ALU control decoder.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_PASS = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is decoded from registered state only, never from out_ready.
    state_t      r_state;
    state_t      w_next_state;

    logic [3:0]  r_sel;
    logic [31:0] r_work;
    logic [4:0]  r_count;
    logic [31:0] r_result;
    logic        r_zf;
    logic        r_sf;
    logic        r_cf;
    logic        r_vf;

    logic        w_is_sub;
    logic        w_is_arith;
    logic [31:0] w_op_b;
    logic [32:0] w_sum;
    logic        w_cf;
    logic        w_vf;
    logic [31:0] w_result;
    logic        w_start_shift;
    logic [31:0] w_work_shift;

    always_comb begin
        w_is_sub   = (sel == ALU_SUB) || (sel == ALU_SLT) || (sel == ALU_SLTU);
        w_is_arith = w_is_sub || (sel == ALU_ADD);
        w_op_b     = w_is_sub ? ~b : b;
        w_sum      = {1'b0, a} + {1'b0, w_op_b} + {32'd0, w_is_sub};
        w_cf       = w_is_arith && w_sum[32];
        w_vf       = w_is_arith && (a[31] == w_op_b[31]) && (w_sum[31] != a[31]);
        case (sel)
            ALU_ADD:  w_result = w_sum[31:0];
            ALU_SUB:  w_result = w_sum[31:0];
            ALU_AND:  w_result = a & b;
            ALU_OR:   w_result = a | b;
            ALU_XOR:  w_result = a ^ b;
            // Signed less-than: sign of the difference corrected by overflow.
            ALU_SLT:  w_result = {31'd0, w_sum[31] ^ w_vf};
            ALU_SLTU: w_result = {31'd0, ~w_sum[32]};
`ifdef ITERATIVE_ALU_BARREL_EN
            ALU_SLL:  w_result = a << b[4:0];
            ALU_SRL:  w_result = a >> b[4:0];
`else
            // Only reached here with a zero amount; nonzero amounts iterate.
            ALU_SLL:  w_result = a;
            ALU_SRL:  w_result = a;
`endif
            default:  w_result = b;
        endcase
`ifdef ITERATIVE_ALU_BARREL_EN
        w_start_shift = 1'b0;
`else
        w_start_shift = ((sel == ALU_SLL) || (sel == ALU_SRL)) && (b[4:0] != 5'd0);
`endif
        w_work_shift = (r_sel == ALU_SLL) ? {r_work[30:0], 1'b0} : {1'b0, r_work[31:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = w_start_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (r_count == 5'd1) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= 4'd0;
            r_work   <= 32'd0;
            r_count  <= 5'd0;
            r_result <= 32'd0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
            r_cf     <= 1'b0;
            r_vf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sel <= sel;
                        if (w_start_shift) begin
                            r_work  <= a;
                            r_count <= b[4:0];
                        end else begin
                            r_result <= w_result;
                            r_zf     <= (w_result == 32'd0);
                            r_sf     <= w_result[31];
                            r_cf     <= w_cf;
                            r_vf     <= w_vf;
                        end
                    end
                end
                SHIFT: begin
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd1) begin
                        r_result <= w_work_shift;
                        r_zf     <= (w_work_shift == 32'd0);
                        r_sf     <= w_work_shift[31];
                        r_cf     <= 1'b0;
                        r_vf     <= 1'b0;
                    end else begin
                        r_work <= w_work_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = r_result;
    assign zf        = r_zf;
    assign sf        = r_sf;
    assign cf        = r_cf;
    assign vf        = r_vf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: vector table plus reset-abort and backpressure sequences.
module tb_iterative_alu;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_PASS = 4'd9;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zf;
    logic        sf;
    logic        cf;
    logic        vf;
    logic [1:0]  dbg_state;

    int checks;
    int failures;

    iterative_alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zf        (zf),
        .sf        (sf),
        .cf        (cf),
        .vf        (vf),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {zf, sf, cf, vf}
    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic [3:0]  exp_flags;
        int          ser_lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int exp_latency(input int ser_lat);
`ifdef ITERATIVE_ALU_BARREL_EN
        return 1;
`else
        return ser_lat;
`endif
    endfunction

    // Drives one bundle from IDLE, measures edges from handshake to out_valid, then completes the handshake.
    task automatic run_op(input vec_t v, input string name);
        int lat;
        bit got;
        @(negedge clk);
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        sel       = v.sel;
        a         = v.a;
        b         = v.b;
        out_ready = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
            if (out_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: out_valid not seen within 100 cycles", name);
        end else begin
            check({name, " result"}, result, v.exp_result);
            check({name, " flags"}, {28'd0, zf, sf, cf, vf}, {28'd0, v.exp_flags});
            check({name, " latency"}, lat, exp_latency(v.ser_lat));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 4'd0;
        a         = 32'd0;
        b         = 32'd0;

        vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1};
        vecs[1]  = '{ALU_SUB,  32'h12345678, 32'h12345678, 32'h00000000, 4'b1010, 1};
        vecs[2]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0010, 1};
        vecs[3]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1};
        vecs[4]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1};
        vecs[5]  = '{ALU_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1};
        vecs[6]  = '{ALU_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 4'b0000, 1};
        vecs[7]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1};
        vecs[8]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0100, 1};
        vecs[9]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1};
        vecs[10] = '{ALU_PASS, 32'h00000123, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0100, 1};
        vecs[11] = '{4'hF,     32'h00000123, 32'h00000000, 32'h00000000, 4'b1000, 1};
        vecs[12] = '{ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 32};
        vecs[13] = '{ALU_SLL,  32'h12345678, 32'h00000020, 32'h12345678, 4'b0000, 1};
        vecs[14] = '{ALU_SLL,  32'h00000001, 32'h00000003, 32'h00000008, 4'b0000, 4};
        vecs[15] = '{ALU_SRL,  32'hF0000000, 32'h00000004, 32'h0F000000, 4'b0000, 5};
        vecs[16] = '{ALU_SLL,  32'h80000001, 32'h00000001, 32'h00000002, 4'b0000, 2};
        vecs[17] = '{ALU_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 4'b0100, 32};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {28'd0, zf, sf, cf, vf}, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-shift: SLL 1 by 20, reset pulse five cycles after the handshake.
        @(negedge clk);
        in_valid = 1'b1;
        sel      = ALU_SLL;
        a        = 32'h00000001;
        b        = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
`ifndef ITERATIVE_ALU_BARREL_EN
        check("midshift out_valid", {31'd0, out_valid}, 32'd0);
        check("midshift in_ready", {31'd0, in_ready}, 32'd0);
`endif
        rst = 1'b1;
        #1;
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort result", result, 32'd0);
        check("abort flags", {28'd0, zf, sf, cf, vf}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("abort no result", seen, 0);
        end

        // Backpressure: AND result held for 10 cycles while a second bundle waits.
        @(negedge clk);
        in_valid  = 1'b1;
        sel       = ALU_AND;
        a         = 32'hF0F0F0F0;
        b         = 32'hFF00FF00;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        sel = ALU_ADD;
        a   = 32'h00000001;
        b   = 32'h00000001;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp result c%0d", c), result, 32'hF000F000);
            check($sformatf("bp hold c%0d", c), {30'd0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp released in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp second out_valid", {31'd0, out_valid}, 32'd1);
        check("bp second result", result, 32'h00000002);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("final idle", {30'd0, dbg_state}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Multi-cycle ALU execution unit that consumes the 4-bit ALU selection code produced by the ALU control decoder and returns a 32-bit result plus condition flags. It sits in the execute stage between the register-file read operands and writeback, and uses a valid/ready handshake on both sides so the pipeline stalls while a shift iterates. Single-cycle operations complete in one cycle. Shifts iterate one bit position per cycle unless the barrel-shift build option is selected.

## Interface
- Parameters: none; data width fixed at 32, shift amount taken from b[4:0].
- Selection encodings: the ALU_* macros in defines.v.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand/selection bundle valid.
- in_ready  out  1  unit can accept a bundle.
- sel  in  4  ALU selection code.
- a  in  32  operand A (rs1).
- b  in  32  operand B (rs2 or immediate).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  operation result.
- zf  out  1  result == 0.
- sf  out  1  result[31].
- cf  out  1  adder carry-out (ADD/SUB/SLT/SLTU only, else 0).
- vf  out  1  adder signed overflow (ADD/SUB/SLT/SLTU only, else 0).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch sel/a/b.
  - Non-shift op: compute, register result/flags, go to DONE.
  - ALU_SLL/ALU_SRL with b[4:0]==0: result=a, go to DONE.
  - Other shifts: load a into work register and b[4:0] into count, go to SHIFT.
- SHIFT: each cycle shift the work register 1 bit (SLL left, SRL logical right, zero fill) and decrement count. When count reaches 1, register the final value and go to DONE.
- DONE: out_valid=1 with result/flags held stable until out_valid&&out_ready, then return to IDLE. in_ready=0 in SHIFT and DONE.
- Operations:
  - ADD: a+b.
  - SUB: a+~b+1.
  - AND, OR, XOR: bitwise.
  - SLT: {31'b0, signed a<b}.
  - SLTU: {31'b0, cf==0}, computed from the a-b subtract.
  - PASS: b.
  - Any undefined sel behaves as PASS.
- Adder flags:
  - cf = bit 32 of the 33-bit sum.
  - vf = (a[31]==op_b[31]) && (sum[31]!=a[31]), where op_b is b for ADD and ~b for SUB/SLT/SLTU.
  - SLT/SLTU flags come from the internal subtract; zf and sf reflect the final result.
- All arithmetic wraps modulo 2^32. No exceptions are raised.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, and all flags 0; state IDLE, count 0.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. No result is produced for it.
- Latency, handshake to out_valid:
  - Non-shift ops: 1 cycle.
  - Shift with amount N≥1: N+1 cycles.
  - Shift with amount 0: 1 cycle.
- Throughput: one bundle per 2 cycles minimum (IDLE → DONE → IDLE). in_ready is registered state, never combinational from out_ready.
- Backpressure: out_ready low holds DONE indefinitely, with outputs stable and no new input accepted.
- in_valid while in_ready=0 is ignored. The producer holds its bundle until the handshake.

## Configuration
- ITERATIVE_ALU_BARREL_EN defined: the SHIFT state is never entered. All shifts complete via a single-cycle barrel shifter with 1-cycle latency, identical to non-shift ops.
- Undefined (default): bit-serial shifting as described above, latency N+1.

## Test plan
- Reset mid-shift: SLL a=1, b=20, assert rst at cycle 5 → out_valid stays 0. After release, in_ready=1, result=0.
- ADD overflow: a=0x7FFFFFFF, b=1 → result=0x80000000, vf=1, cf=0, sf=1, zf=0, latency 1.
- SUB equal: a=b=0x12345678 → result=0, zf=1, cf=1, vf=0.
- Set-less-than comparisons with a=0xFFFFFFFF, b=1:
  - SLT → result=1.
  - SLTU → result=0.
- Shifts:
  - SRL a=0x80000000, b=31 → result=1 after 32 cycles (1 cycle with ITERATIVE_ALU_BARREL_EN).
  - SLL b=0 → result=a after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles after an AND of a=0xF0F0F0F0, b=0xFF00FF00 → result 0xF000F000 stays stable, in_ready=0, and a second in_valid is not accepted until the handshake.
